// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage bus: program handshake, control inputs, instruction memory port
interface fetch_unit_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 9
);
    logic               start;
    logic [PC_W-1:0]    start_addr;
    logic               stall;
    logic               branch;
    logic               branch_cond;
    logic               jmp_ctrl;
    logic [PC_W-1:0]    jmp_target;
    logic               done_ctrl;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic [INSTR_W-1:0] instruction;
    logic               instr_valid;
    logic [PC_W-1:0]    pc;
    logic               done;
`ifdef FETCH_INSTR_COUNT_EN
    logic [31:0]        instr_count;
`endif

    modport slave (
        input  start, start_addr, stall, branch, branch_cond,
        input  jmp_ctrl, jmp_target, done_ctrl, imem_data,
        output imem_addr, instruction, instr_valid, pc, done
`ifdef FETCH_INSTR_COUNT_EN
        , output instr_count
`endif
    );

    modport master (
        output start, start_addr, stall, branch, branch_cond,
        output jmp_ctrl, jmp_target, done_ctrl, imem_data,
        input  imem_addr, instruction, instr_valid, pc, done
`ifdef FETCH_INSTR_COUNT_EN
        , input instr_count
`endif
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC/fetch stage with IDLE/RUN/HALT sequencing; FETCH_INSTR_COUNT_EN adds a retired-instruction counter
module fetch_unit #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 9
) (
    input  logic           clock,
    input  logic           reset_n,
    fetch_unit_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] branch_offset;
    logic            start_accept;
    logic            retire;

    // 5-bit signed branch offset, sign-extended to PC width so the add wraps naturally
    assign branch_offset = {{(PC_W-5){bus.instruction[4]}}, bus.instruction[4:0]};
    assign start_accept  = bus.start && (state_q == IDLE || state_q == HALT);
    assign retire        = (state_q == RUN) && !bus.stall;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            IDLE, HALT: begin
                if (bus.start) begin
                    pc_d    = bus.start_addr;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!bus.stall) begin
                    if (bus.done_ctrl)
                        state_d = HALT;
                    else if (bus.jmp_ctrl)
                        pc_d = bus.jmp_target;
                    else if (bus.branch && bus.branch_cond)
                        pc_d = pc_q + branch_offset;
                    else
                        pc_d = pc_q + PC_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.pc          = pc_q;
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = (state_q == RUN);
    assign bus.done        = (state_q == HALT);
    assign bus.instruction = (state_q == RUN) ? bus.imem_data : '0;

`ifdef FETCH_INSTR_COUNT_EN
    logic [31:0] count_q;

    always_ff @(posedge clock) begin
        if (!reset_n || start_accept)
            count_q <= '0;
        else if (retire && count_q != 32'hFFFF_FFFF)
            count_q <= count_q + 32'd1;
    end

    assign bus.instr_count = count_q;
`else
    logic unused_ok;
    assign unused_ok = start_accept ^ retire;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed plus randomized check of fetch_unit against a behavioural model
module tb_fetch_unit;
    localparam int PC_W    = 8;
    localparam int INSTR_W = 9;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    fetch_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

    fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clock = ~clock;

    logic [INSTR_W-1:0] mem [0:255];
    assign bus.imem_data = mem[bus.imem_addr];

    int checks = 0;
    int errors = 0;

    // model: mode 0 = idle, 1 = running, 2 = halted
    int     mode_m = 0;
    int     pc_m   = 0;
    longint cnt_m  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int offset_of(input logic [INSTR_W-1:0] w);
        int off;
        off = int'(w[4:0]);
        if (off >= 16) off = off - 32;
        return off;
    endfunction

    task automatic model_edge();
        if (!reset_n) begin
            mode_m = 0; pc_m = 0; cnt_m = 0;
        end else if (mode_m == 0 || mode_m == 2) begin
            if (bus.start) begin
                mode_m = 1; pc_m = int'(bus.start_addr); cnt_m = 0;
            end
        end else if (!bus.stall) begin
            if (cnt_m < 64'hFFFF_FFFF) cnt_m = cnt_m + 1;
            if (bus.done_ctrl)
                mode_m = 2;
            else if (bus.jmp_ctrl)
                pc_m = int'(bus.jmp_target);
            else if (bus.branch && bus.branch_cond)
                pc_m = (pc_m + offset_of(mem[pc_m]) + 256) % 256;
            else
                pc_m = (pc_m + 1) % 256;
        end
    endtask

    task automatic compare_all();
        check("pc", 32'(bus.pc), 32'(pc_m));
        check("imem_addr", 32'(bus.imem_addr), 32'(pc_m));
        check("instr_valid", 32'(bus.instr_valid), 32'(mode_m == 1));
        check("done", 32'(bus.done), 32'(mode_m == 2));
        check("instruction", 32'(bus.instruction), (mode_m == 1) ? 32'(mem[pc_m]) : 32'd0);
`ifdef FETCH_INSTR_COUNT_EN
        check("instr_count", bus.instr_count, 32'(cnt_m));
`endif
    endtask

    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
        compare_all();
    endtask

    task automatic clear_inputs();
        bus.start = 0; bus.start_addr = '0; bus.stall = 0; bus.branch = 0;
        bus.branch_cond = 0; bus.jmp_ctrl = 0; bus.jmp_target = '0; bus.done_ctrl = 0;
    endtask

    task automatic jump_to(input logic [7:0] t);
        bus.jmp_ctrl = 1; bus.jmp_target = t;
        step();
        bus.jmp_ctrl = 0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = INSTR_W'($urandom);
        mem[8'h20] = 9'h01C;
        clear_inputs();
        reset_n = 0;
        step();
        step();
        check("rst_pc", 32'(bus.pc), 32'h0);
        check("rst_valid", 32'(bus.instr_valid), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        reset_n = 1;
        step();
        check("idle_pc", 32'(bus.pc), 32'h0);

        bus.start = 1; bus.start_addr = 8'h10;
        step();
        bus.start = 0;
        check("start_pc", 32'(bus.pc), 32'h10);
        check("start_valid", 32'(bus.instr_valid), 32'h1);
        step();
        check("inc_pc1", 32'(bus.pc), 32'h11);
        step();
        check("inc_pc2", 32'(bus.pc), 32'h12);
        for (int i = 0; i < 20 && pc_m != 8'h20; i++) step();
        check("reach_20", 32'(bus.pc), 32'h20);

        bus.branch = 1; bus.branch_cond = 1;
        step();
        check("br_taken", 32'(bus.pc), 32'h1C);
        bus.branch = 0; bus.branch_cond = 0;
        jump_to(8'h20);
        bus.branch = 1; bus.branch_cond = 0;
        step();
        check("br_not_taken", 32'(bus.pc), 32'h21);
        bus.branch = 0;

        jump_to(8'h05);
        jump_to(8'hFF);
        check("jmp_ff", 32'(bus.pc), 32'hFF);
        step();
        check("wrap_00", 32'(bus.pc), 32'h00);

        jump_to(8'h30);
        bus.stall = 1; bus.done_ctrl = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", 32'(bus.pc), 32'h30);
            check("stall_done", 32'(bus.done), 32'h0);
        end
        bus.stall = 0;
        step();
        bus.done_ctrl = 0;
        check("halt_done", 32'(bus.done), 32'h1);
        check("halt_valid", 32'(bus.instr_valid), 32'h0);
        check("halt_pc", 32'(bus.pc), 32'h30);

        bus.start = 1; bus.start_addr = 8'h40;
        step();
        bus.start = 0;
        check("restart_done", 32'(bus.done), 32'h0);
        check("restart_pc", 32'(bus.pc), 32'h40);
        check("restart_valid", 32'(bus.instr_valid), 32'h1);
        step();
        reset_n = 0;
        step();
        reset_n = 1;
        check("midrst_pc", 32'(bus.pc), 32'h0);
        check("midrst_valid", 32'(bus.instr_valid), 32'h0);

        bus.start = 1; bus.start_addr = 8'h50;
        step();
        bus.start = 0;
        step();
        bus.stall = 1;
        step();
        bus.stall = 0;
        for (int i = 0; i < 3; i++) step();
        bus.done_ctrl = 1;
        step();
        bus.done_ctrl = 0;
        check("halt5_done", 32'(bus.done), 32'h1);
`ifdef FETCH_INSTR_COUNT_EN
        check("count_5", bus.instr_count, 32'd5);
`endif
        bus.start = 1; bus.start_addr = 8'h60;
        step();
        bus.start = 0;
        check("start_again_pc", 32'(bus.pc), 32'h60);
`ifdef FETCH_INSTR_COUNT_EN
        check("count_cleared", bus.instr_count, 32'd0);
`endif

        for (int i = 0; i < 3000; i++) begin
            reset_n         = ($urandom_range(0, 63) != 0);
            bus.start       = ($urandom_range(0, 15) == 0);
            bus.start_addr  = PC_W'($urandom);
            bus.stall       = ($urandom_range(0, 3) == 0);
            bus.done_ctrl   = ($urandom_range(0, 31) == 0);
            bus.jmp_ctrl    = ($urandom_range(0, 7) == 0);
            bus.jmp_target  = PC_W'($urandom);
            bus.branch      = ($urandom_range(0, 3) == 0);
            bus.branch_cond = 1'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program-counter and instruction-fetch stage that sits directly upstream of the control unit.
- Holds the PC, drives the instruction-memory address, and presents the 9-bit instruction word to decode.
- Resolves next-PC from the control unit's branch, jmp_ctrl and done_ctrl outputs plus the datapath compare result.
- Runs a start/done program-level handshake with the testbench or top level.

Parameters:
- PC_W, 8, program counter and instruction-memory address width (max 2^PC_W instructions).
- INSTR_W, 9, instruction word width; fixed ISA width, not meant to change.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  synchronous active-low reset.
- start  input  1  single-cycle pulse: begin execution at start_addr.
- start_addr  input  PC_W  first instruction address, sampled when start is accepted.
- stall  input  1  hold PC and state this cycle (multi-cycle memory access).
- branch  input  1  from control unit: current instruction is a conditional branch.
- branch_cond  input  1  from datapath compare: branch condition true.
- jmp_ctrl  input  1  from control unit: current instruction is an unconditional jump.
- jmp_target  input  PC_W  absolute jump address (register value from datapath).
- done_ctrl  input  1  from control unit: current instruction is halt.
- imem_addr  output  PC_W  instruction memory address; equals pc.
- imem_data  input  INSTR_W  instruction memory read data; combinational, same cycle as imem_addr.
- instruction  output  INSTR_W  instruction to decode; equals imem_data in RUN, 9'h000 otherwise.
- instr_valid  output  1  high in RUN; downstream gates reg_write and mem_write with it.
- pc  output  PC_W  current program counter.
- done  output  1  program halted; level signal.

Behaviour:
- States: IDLE, RUN, HALT. State is stored in a 2-bit register; the unused encoding 2'b11 goes to IDLE on the next clock.
- Reset (reset_n = 0 at clock edge):
  - state = IDLE, pc = 0, done = 0.
  - instr_valid = 0, instruction = 0, imem_addr = 0.
  - Reset overrides every other input, including mid-program.
- IDLE:
  - instr_valid = 0, done = 0, pc holds.
  - start = 1 -> pc <= start_addr, state <= RUN.
- RUN, per cycle, in priority order:
  - stall = 1 -> pc and state hold; all other inputs ignored.
  - done_ctrl = 1 -> state <= HALT, pc holds (pc stays on the halt instruction).
  - jmp_ctrl = 1 -> pc <= jmp_target.
  - branch & branch_cond -> pc <= pc + sign_extend(instruction[4:0]), a signed offset from -16 to +15.
  - Otherwise -> pc <= pc + 1.
  - All PC arithmetic is modulo 2^PC_W: wrap at 2^PC_W-1 -> 0, and negative offsets wrap downward.
  - A branch offset of 0 is a self-loop; this is legal.
  - branch = 1 with branch_cond = 0 falls through to pc + 1.
  - start is ignored in RUN.
- HALT:
  - done = 1, instr_valid = 0, pc holds.
  - start = 1 -> pc <= start_addr, done <= 0, state <= RUN on the same edge.
- Outputs are combinational from the state and pc registers; there are no other registered outputs.
- Fetch latency is 0 cycles: the instruction at pc is valid in the same cycle.
- Next-PC takes effect one cycle later, so each instruction occupies exactly one non-stalled cycle.
- If stall and done_ctrl are high together, stall wins and the halt is taken on the first non-stalled cycle.

Optional Feature:
- Macro: FETCH_INSTR_COUNT_EN.
- When defined:
  - Adds output instr_count [31:0], the count of retired instructions.
  - Increments on every RUN cycle with stall = 0, including the halt instruction.
  - Cleared by reset and when start is accepted; holds in IDLE and HALT; saturates at 32'hFFFF_FFFF.
- When undefined: the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Reset and start: hold reset_n = 0 for 2 clocks, then pulse start with start_addr = 8'h10. Required: pc = 0, instr_valid = 0, done = 0 before start; the next cycle pc = 8'h10 and instr_valid = 1; pc then increments 0x11, 0x12, ... on successive cycles.
- Taken branch: at pc = 8'h20 drive branch = 1, branch_cond = 1 with instruction[4:0] = 5'b11100 (-4). Required: next pc = 8'h1C. Repeat with branch_cond = 0. Required: next pc = 8'h21.
- Jump and wrap: at pc = 8'h05 drive jmp_ctrl = 1, jmp_target = 8'hFF. Required: next pc = 8'hFF, then 8'h00.
- Stall and halt collision: at pc = 8'h30 hold stall = 1 and done_ctrl = 1 for 3 cycles, then drop stall. Required: pc stays 8'h30 and done = 0 during the stall; one cycle after stall drops, done = 1 and instr_valid = 0 with pc at 8'h30.
- Restart from HALT and mid-run reset:
  - Pulse start with start_addr = 8'h40 while in HALT. Required: done falls and pc = 8'h40 with instr_valid = 1.
  - Assert reset_n = 0 mid-run. Required: the next cycle is IDLE with pc = 0.
- FETCH_INSTR_COUNT_EN build: run 5 instructions including the halt, with one stall cycle inserted. Required: instr_count = 5; after a new start it reads 0.
